sweep_capture_engine: RTL and testbench

SWEEP_CAPTURE_ENGINE -- requirements
Module: sweep_capture_engine

---
 rtl/sweep_capture_engine.sv | 113 +++++++++++
 tb/tb_sweep_capture_engine.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sweep_capture_engine.sv
// sweep_capture_engine: sweeps all 2^IN_W stimulus vectors, captures DUT responses via valid/ready and compacts them into a signature; SWEEP_GRAY_MODE_EN enables Gray-order sweeps
module sweep_capture_engine #(
  parameter int unsigned IN_W = 6,
  parameter int unsigned OUT_W = 1,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned SIG_W = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic [IN_W-1:0]  smp_vec,
  output logic [OUT_W-1:0] smp_resp,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [IN_W:0]    vec_count
);
`ifdef SWEEP_GRAY_MODE_EN
  localparam logic GRAY = 1'b1;
`else
  localparam logic GRAY = 1'b0;
`endif
  localparam logic [7:0] LAST_CNT = 8'(SETTLE - 1);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  state_t state_q, state_d;
  logic [IN_W-1:0] idx_q, idx_d, dut_in_q, dut_in_d, smp_vec_q, smp_vec_d;
  logic [OUT_W-1:0] smp_resp_q, smp_resp_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [IN_W:0] vc_q, vc_d;
  logic [7:0] cnt_q, cnt_d;
  logic mode_q, mode_d;
  function automatic logic [IN_W-1:0] enc(input logic [IN_W-1:0] i, input logic g);
    return g ? i ^ (i >> 1) : i;
  endfunction
  // state and datapath registers; reset wins over a coincident start
  always_ff @(posedge CK) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      dut_in_q <= '0;
      smp_vec_q <= '0;
      smp_resp_q <= '0;
      sig_q <= '0;
      vc_q <= '0;
      cnt_q <= '0;
      mode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      dut_in_q <= dut_in_d;
      smp_vec_q <= smp_vec_d;
      smp_resp_q <= smp_resp_d;
      sig_q <= sig_d;
      vc_q <= vc_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
    end
  end
  // next-state: settle for SETTLE cycles, capture, hand off, advance or finish
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    dut_in_d = dut_in_q;
    smp_vec_d = smp_vec_q;
    smp_resp_d = smp_resp_q;
    sig_d = sig_q;
    vc_d = vc_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = APPLY;
        idx_d = '0;
        dut_in_d = '0;
        sig_d = '0;
        vc_d = '0;
        cnt_d = '0;
        mode_d = mode & GRAY;
      end
      APPLY: if (cnt_q == LAST_CNT) begin
        smp_resp_d = dut_out;
        smp_vec_d = dut_in_q;
        state_d = SAMPLE;
      end else cnt_d = cnt_q + 8'd1;
      SAMPLE: if (smp_ready) begin
        vc_d = vc_q + 1'b1;
        sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? SIG_POLY : '0) ^ SIG_W'(smp_resp_q);
        cnt_d = '0;
        if (&idx_q) state_d = DONE;
        else begin
          idx_d = idx_q + 1'b1;
          dut_in_d = enc(idx_q + 1'b1, mode_q);
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign dut_in = dut_in_q;
  assign smp_vec = smp_vec_q;
  assign smp_resp = smp_resp_q;
  assign smp_valid = state_q == SAMPLE;
  assign busy = state_q == APPLY || state_q == SAMPLE;
  assign done = state_q == DONE;
  assign signature = sig_q;
  assign vec_count = vc_q;
endmodule

// File: tb/tb_sweep_capture_engine.sv
// tb_sweep_capture_engine: table-driven sweeps with a transfer scoreboard plus stall, reset and restart sequences
module tb_sweep_capture_engine;
  localparam int IN_W = 6;
  logic CK = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, smp_ready = 1'b1, startb = 1'b0;
  int sel = 0;
  logic [IN_W-1:0] dut_in, smp_vec;
  logic dut_out, smp_valid, smp_resp, busy, done;
  logic [15:0] signature;
  logic [IN_W:0] vec_count;
  logic [1:0] dut_in_b, smp_vec_b;
  logic smp_valid_b, smp_resp_b, busy_b, done_b;
  logic [15:0] sig_b;
  logic [2:0] vc_b;
  int checks = 0, passes = 0;
  always #5 CK = ~CK;
  assign dut_out = sel == 0 ? ^dut_in : (sel == 2);
  sweep_capture_engine dut (
    .CK(CK), .reset(reset), .start(start), .mode(mode), .dut_in(dut_in), .dut_out(dut_out),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_vec(smp_vec), .smp_resp(smp_resp),
    .busy(busy), .done(done), .signature(signature), .vec_count(vec_count)
  );
  sweep_capture_engine #(.IN_W(2), .SETTLE(3)) dut_b (
    .CK(CK), .reset(reset), .start(startb), .mode(1'b0), .dut_in(dut_in_b), .dut_out(1'b1),
    .smp_valid(smp_valid_b), .smp_ready(1'b1), .smp_vec(smp_vec_b), .smp_resp(smp_resp_b),
    .busy(busy_b), .done(done_b), .signature(sig_b), .vec_count(vc_b)
  );
  typedef struct {
    logic m;
    int sel;
    bit stall;
    bit rst20;
    bit restart;
    int exp_cyc;
    logic [15:0] exp_sig;
  } row_t;
  typedef struct {
    logic [IN_W-1:0] vec;
    logic resp;
  } rec_t;
  row_t rows[7];
  rec_t q[$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endtask
  function automatic logic [IN_W-1:0] enc(input int i, input logic g);
    logic [IN_W-1:0] v = IN_W'(i);
    return g ? v ^ (v >> 1) : v;
  endfunction
  function automatic logic resp_of(input logic [IN_W-1:0] v, input int s);
    return s == 0 ? ^v : (s == 2);
  endfunction
  function automatic logic gsel(input logic m);
`ifdef SWEEP_GRAY_MODE_EN
    return m;
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [15:0] sig_model(input logic m, input int s);
    logic [15:0] g = 16'h0;
    for (int i = 0; i < 64; i++)
      g = {g[14:0], 1'b0} ^ (g[15] ? 16'h1021 : 16'h0) ^ 16'(resp_of(enc(i, gsel(m)), s));
    return g;
  endfunction
  task automatic tick;
    @(posedge CK);
    #1;
  endtask
  rec_t r;
  always @(negedge CK) if (!reset) begin
    if (smp_valid) chk("valid_while_busy", busy, 1);
    if (smp_valid && smp_ready) begin
      if (q.size() == 0) chk("sb_extra_xfer", q.size(), 1);
      else begin
        r = q.pop_front();
        chk("sb_vec", smp_vec, r.vec);
        chk("sb_resp", smp_resp, r.resp);
        chk("sb_dut_in", dut_in, r.vec);
      end
    end
  end
  task automatic run(input row_t rw, input string tag);
    int cyc;
    bit stalled = 0, restarted = 0;
    q.delete();
    sel = rw.sel;
    mode = rw.m;
    for (int i = 0; i < 64; i++) q.push_back('{enc(i, gsel(rw.m)), resp_of(enc(i, gsel(rw.m)), rw.sel)});
    start = 1'b1;
    tick;
    start = 1'b0;
    mode = ~rw.m;
    cyc = 1;
    chk({tag, "_busy_first"}, busy, 1);
    chk({tag, "_dut_in_first"}, dut_in, 0);
    while (!done && cyc < 1000) begin
      start = 1'b0;
      if (rw.rst20 && vec_count == 20) begin
        reset = 1'b1;
        start = 1'b1;
        tick;
        reset = 1'b0;
        start = 1'b0;
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_dut_in"}, dut_in, 0);
        chk({tag, "_rst_vc"}, vec_count, 0);
        chk({tag, "_rst_sig"}, signature, 0);
        chk({tag, "_rst_valid"}, smp_valid, 0);
        tick;
        chk({tag, "_rst_start_ignored"}, busy, 0);
        q.delete();
        return;
      end
      if (rw.stall && !stalled && smp_valid && smp_vec == 3) begin
        stalled = 1;
        smp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          tick;
          cyc++;
          chk({tag, "_stall_valid"}, smp_valid, 1);
          chk({tag, "_stall_vec"}, smp_vec, 3);
          chk({tag, "_stall_resp"}, smp_resp, 0);
          chk({tag, "_stall_dut_in"}, dut_in, 3);
        end
        smp_ready = 1'b1;
      end
      if (rw.restart && !restarted && dut_in == 10) begin
        restarted = 1;
        start = 1'b1;
      end
      tick;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, cyc, rw.exp_cyc);
    chk({tag, "_vc_at_done"}, vec_count, 64);
    chk({tag, "_sig_at_done"}, signature, rw.exp_sig);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_sb_drained"}, q.size(), 0);
    tick;
    chk({tag, "_done_pulse_one"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    tick;
    chk({tag, "_sig_held"}, signature, rw.exp_sig);
    chk({tag, "_vc_held"}, vec_count, 64);
  endtask
  initial begin
    int cyc;
    repeat (3) tick;
    chk("reset_dut_in", dut_in, 0);
    chk("reset_smp_vec", smp_vec, 0);
    chk("reset_smp_resp", smp_resp, 0);
    chk("reset_valid", smp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sig", signature, 0);
    chk("reset_vc", vec_count, 0);
    chk("reset_b_sig", sig_b, 0);
    reset = 1'b0;
    tick;
    rows[0] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 129, sig_model(1'b0, 0)};
    rows[1] = '{1'b1, 0, 1'b0, 1'b0, 1'b0, 129, sig_model(1'b1, 0)};
    rows[2] = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 134, sig_model(1'b0, 0)};
    rows[3] = '{1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 16'h0};
    rows[4] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, 129, sig_model(1'b0, 0)};
    rows[5] = '{1'b0, 1, 1'b0, 1'b0, 1'b1, 129, 16'h0000};
    rows[6] = '{1'b0, 2, 1'b0, 1'b0, 1'b0, 129, sig_model(1'b0, 2)};
    for (int i = 0; i < 7; i++) run(rows[i], $sformatf("row%0d", i));
    startb = 1'b1;
    tick;
    startb = 1'b0;
    cyc = 1;
    while (!done_b && cyc < 200) begin
      tick;
      cyc++;
    end
    chk("small_done_cycle", cyc, 17);
    chk("small_sig", sig_b, 16'h000F);
    chk("small_vc", vc_b, 4);
    tick;
    chk("small_done_pulse_one", done_b, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
